gemm_tile_sequencer: RTL and testbench
======================================

Name: gemm_tile_sequencer

Overview:
- Command front-end between host and the tile-level control unit.
- Queues host GEMM commands of arbitrary M/K/N up to 2^LEN_WIDTH-1.
- Splits each command into SYSTOLIC_ARRAY_WIDTH-sized tile commands in the control unit's 64-bit packed format, one outstanding tile at a time.
- Chains K-partial sums through buffer D and signals completion per host command.

Parameters:
ADDR_WIDTH, 10, buffer row address width
SYSTOLIC_ARRAY_WIDTH, 16, tile edge W; legal range 2..255
LEN_WIDTH, 12, width of each host dimension field
QUEUE_DEPTH, 4, host command FIFO entries (power of 2)

Ports:
clk  in  1  single clock
rst  in  1  reset: synchronous, active-low (rst==0 resets on posedge clk)
host_cmd_valid  in  1  host command offered
host_cmd_ready  out  1  FIFO not full
host_cmd_data  in  4*ADDR_WIDTH+3*LEN_WIDTH  {addr_d, addr_c, addr_b, addr_a, dim_n, dim_k, dim_m}, dim_m in LSBs
tile_cmd_valid  out  1  tile command offered to control unit
tile_cmd_ready  in  1  control unit ready
tile_cmd_data  out  4*ADDR_WIDTH+24  {addr_d, addr_c, addr_b, addr_a, len_n[7:0], len_k[7:0], len_m[7:0]}
tile_done  in  1  one-cycle pulse from control unit on tile completion
busy  out  1  FSM not IDLE or FIFO non-empty
cmd_done  out  1  one-cycle pulse per host command retired
cmd_err  out  1  one-cycle pulse with cmd_done when command rejected
queue_level  out  $clog2(QUEUE_DEPTH+1)  FIFO occupancy

Behaviour:
- Reset values: all outputs 0, except host_cmd_ready=1. FIFO emptied, FSM=IDLE, counters 0. Reset mid-operation drops the active command and all queued commands with no done pulse; a later tile_done is ignored.
- FIFO push on host_cmd_valid&&host_cmd_ready. Pop only in IDLE when non-empty. Push and pop in the same cycle both take effect; level unchanged. host_cmd_ready=(level<QUEUE_DEPTH), registered.
- FSM states: IDLE -> LOAD (pop) -> ISSUE -> WAIT -> ADVANCE -> ISSUE ... -> FINISH -> IDLE.
- LOAD:
  - Latch fields.
  - Tile counts: MT=ceil(M/W), KT=ceil(K/W), NT=ceil(N/W).
  - Stride: NTW=NT*W.
  - Clear mi/ni/ki.
  - Any dimension==0 -> FINISH with err flag set. No tile is issued.
- Tile order: mi outer, ni middle, ki inner. This keeps K-accumulation into one D tile consecutive.
- Tile command fields, all modulo 2^ADDR_WIDTH (wrap silently):
  - a = addr_a + (mi*KT+ki)*W
  - b = addr_b + (ki*NT+ni)*W
  - d = addr_d + (mi*NT+ni)*W
  - c = (ki==0) ? addr_c+(mi*NT+ni)*W : d
- Pointers update incrementally in ADVANCE (adders only). No multiplier on the per-tile path; the single multiply is in LOAD.
- Tile lengths:
  - len_m = min(W, M-mi*W); len_k and len_n likewise.
  - Edge tiles carry the remainder.
- ISSUE: tile_cmd_valid=1, data stable until tile_cmd_valid&&tile_cmd_ready, then -> WAIT.
- WAIT: hold until tile_done. A tile_done arriving in ISSUE or IDLE is ignored.
- ADVANCE: step counters. After the last tile (mi=MT-1, ni=NT-1, ki=KT-1) -> FINISH, else -> ISSUE.
- FINISH: cmd_done=1 (cmd_err=err flag) for exactly one cycle, -> IDLE.
- Latencies:
  - Accept to first tile_cmd_valid: 2 cycles in from empty IDLE (pop, LOAD).
  - tile_done to next valid: 2 cycles.
  - Last tile_done to cmd_done: 2 cycles.

Optional Feature:
- Macro: GEMM_TILE_PERF_CNT_EN.
- Defined: adds outputs perf_tiles (32 bit, tiles issued since reset) and perf_stall (32 bit, cycles in ISSUE with tile_cmd_ready=0). Both saturate at 2^32-1 and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- M=K=N=16, a=b=c=0x100, d=0x200, tile_cmd_ready=1:
  - one tile {0x200,0x100,0x100,0x100,16,16,16}
  - cmd_done 2 cycles after tile_done, cmd_err=0
- M=16, K=40, N=16, a=0x000, c=0x100, d=0x200:
  - 3 tiles, len_k 16,16,8
  - a = 0x000, 0x010, 0x020
  - c = 0x100, 0x200, 0x200
  - d = 0x200 all
- M=32, K=16, N=20, d=0x300:
  - 4 tiles in order (0,0),(0,1),(1,0),(1,1)
  - len_n 16,4,16,4; len_m 16 all
  - d = 0x300, 0x310, 0x320, 0x330
- dim_k=0:
  - no tile_cmd_valid
  - cmd_done and cmd_err pulse together 2 cycles after pop
  - next queued command then runs normally
- tile_cmd_ready held 0, push 6 commands:
  - 5 accepted (1 active + 4 queued); host_cmd_ready low at level 4
  - releasing ready drains all 5 commands in push order
  - with GEMM_TILE_PERF_CNT_EN defined, perf_stall equals cycles held
- Drive rst=0 for one cycle while in WAIT:
  - next cycle all outputs at reset values, queue_level=0
  - a following tile_done produces no cmd_done

Source files
------------

// File: rtl/gemm_tile_sequencer.sv
// =============================================================================
// Module   : gemm_tile_sequencer
// Brief    : Queues host GEMM commands and splits them into W x W tile commands,
//            chaining K-partial sums through buffer D. Optional macro
//            GEMM_TILE_PERF_CNT_EN adds perf_tiles / perf_stall counters.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module gemm_tile_sequencer #(
   parameter int ADDR_WIDTH           = 10,
   parameter int SYSTOLIC_ARRAY_WIDTH = 16,
   parameter int LEN_WIDTH            = 12,
   parameter int QUEUE_DEPTH          = 4
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    host_cmd_valid,
   output logic                                    host_cmd_ready,
   input  logic [4*ADDR_WIDTH+3*LEN_WIDTH-1:0]     host_cmd_data,
   output logic                                    tile_cmd_valid,
   input  logic                                    tile_cmd_ready,
   output logic [4*ADDR_WIDTH+23:0]                tile_cmd_data,
   input  logic                                    tile_done,
   output logic                                    busy,
   output logic                                    cmd_done,
   output logic                                    cmd_err,
`ifdef GEMM_TILE_PERF_CNT_EN
   output logic [$clog2(QUEUE_DEPTH+1)-1:0]        queue_level,
   output logic [31:0]                             perf_tiles,
   output logic [31:0]                             perf_stall
`else
   output logic [$clog2(QUEUE_DEPTH+1)-1:0]        queue_level
`endif
);

   localparam int c_CMD_W = 4*ADDR_WIDTH + 3*LEN_WIDTH;
   localparam int c_LVL_W = $clog2(QUEUE_DEPTH+1);
   localparam int c_PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] c_W_A  = ADDR_WIDTH'(SYSTOLIC_ARRAY_WIDTH);
   localparam logic [LEN_WIDTH-1:0]  c_W_LW = LEN_WIDTH'(SYSTOLIC_ARRAY_WIDTH);
   localparam logic [LEN_WIDTH:0]    c_W_X  = (LEN_WIDTH+1)'(SYSTOLIC_ARRAY_WIDTH);
   localparam logic [LEN_WIDTH:0]    c_W_M1 = (LEN_WIDTH+1)'(SYSTOLIC_ARRAY_WIDTH-1);
   localparam logic [7:0]            c_W_8  = 8'(SYSTOLIC_ARRAY_WIDTH);
   localparam logic [c_LVL_W-1:0]    c_QD   = c_LVL_W'(QUEUE_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_ISSUE   = 3'd2,
      S_WAIT    = 3'd3,
      S_ADVANCE = 3'd4,
      S_FINISH  = 3'd5
   } state_t;

   function automatic logic [LEN_WIDTH-1:0] f_tiles(input logic [LEN_WIDTH-1:0] dim);
      return LEN_WIDTH'(({1'b0, dim} + c_W_M1) / c_W_X);
   endfunction

   function automatic logic [7:0] f_len(input logic [LEN_WIDTH-1:0] rem);
      return (rem >= c_W_LW) ? c_W_8 : 8'(rem);
   endfunction

   // ---------------------------------------------------------------- FIFO
   logic [c_CMD_W-1:0]  mem_q [QUEUE_DEPTH];
   logic [c_PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [c_LVL_W-1:0]  level_q, level_d;
   logic                ready_q;
   logic                w_push, w_pop;
   logic [c_CMD_W-1:0]  w_head;

   state_t state_q, state_d;

   assign w_push = host_cmd_valid && ready_q;
   assign w_pop  = (state_q == S_IDLE) && (level_q != '0);
   assign w_head = mem_q[rd_ptr_q];

   always_comb begin
      level_d = level_q;
      if (w_push && !w_pop) begin
         level_d = level_q + 1'b1;
      end else if (!w_push && w_pop) begin
         level_d = level_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= host_cmd_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ready_q  <= 1'b1;
      end else begin
         if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         level_q <= level_d;
         ready_q <= (level_d < c_QD);
      end
   end

   // ------------------------------------------------------ command state
   logic [c_CMD_W-1:0]    cmd_q, cmd_d;
   logic                  err_q, err_d;
   logic [LEN_WIDTH-1:0]  mt_q, mt_d, kt_q, kt_d, nt_q, nt_d;
   logic [LEN_WIDTH-1:0]  mi_q, mi_d, ni_q, ni_d, ki_q, ki_d;
   logic [LEN_WIDTH-1:0]  rem_m_q, rem_m_d, rem_n_q, rem_n_d, rem_k_q, rem_k_d;
   logic [ADDR_WIDTH-1:0] ntw_q, ntw_d;
   logic [ADDR_WIDTH-1:0] a_q, a_d, a_row_q, a_row_d, b_q, b_d, b_col_q, b_col_d;
   logic [ADDR_WIDTH-1:0] c_q, c_d, d_q, d_d;

   logic [LEN_WIDTH-1:0]  w_dim_m, w_dim_k, w_dim_n, w_mt, w_kt, w_nt;
   logic [ADDR_WIDTH-1:0] w_addr_a, w_addr_b, w_addr_c, w_addr_d, w_ntw;
   logic                  w_zero_dim, w_last_m, w_last_n, w_last_k;

   assign w_dim_m  = cmd_q[0 +: LEN_WIDTH];
   assign w_dim_k  = cmd_q[LEN_WIDTH +: LEN_WIDTH];
   assign w_dim_n  = cmd_q[2*LEN_WIDTH +: LEN_WIDTH];
   assign w_addr_a = cmd_q[3*LEN_WIDTH +: ADDR_WIDTH];
   assign w_addr_b = cmd_q[3*LEN_WIDTH+ADDR_WIDTH +: ADDR_WIDTH];
   assign w_addr_c = cmd_q[3*LEN_WIDTH+2*ADDR_WIDTH +: ADDR_WIDTH];
   assign w_addr_d = cmd_q[3*LEN_WIDTH+3*ADDR_WIDTH +: ADDR_WIDTH];

   assign w_mt       = f_tiles(w_dim_m);
   assign w_kt       = f_tiles(w_dim_k);
   assign w_nt       = f_tiles(w_dim_n);
   assign w_ntw      = ADDR_WIDTH'({9'd0, w_nt} * (LEN_WIDTH+9)'(SYSTOLIC_ARRAY_WIDTH));
   assign w_zero_dim = (w_dim_m == '0) || (w_dim_k == '0) || (w_dim_n == '0);

   assign w_last_m = (mi_q == mt_q - 1'b1);
   assign w_last_n = (ni_q == nt_q - 1'b1);
   assign w_last_k = (ki_q == kt_q - 1'b1);

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      err_d   = err_q;
      mt_d    = mt_q;
      kt_d    = kt_q;
      nt_d    = nt_q;
      ntw_d   = ntw_q;
      mi_d    = mi_q;
      ni_d    = ni_q;
      ki_d    = ki_q;
      rem_m_d = rem_m_q;
      rem_n_d = rem_n_q;
      rem_k_d = rem_k_q;
      a_d     = a_q;
      a_row_d = a_row_q;
      b_d     = b_q;
      b_col_d = b_col_q;
      c_d     = c_q;
      d_d     = d_q;
      case (state_q)
         S_IDLE: begin
            if (w_pop) begin
               cmd_d   = w_head;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            mt_d    = w_mt;
            kt_d    = w_kt;
            nt_d    = w_nt;
            ntw_d   = w_ntw;
            mi_d    = '0;
            ni_d    = '0;
            ki_d    = '0;
            rem_m_d = w_dim_m;
            rem_n_d = w_dim_n;
            rem_k_d = w_dim_k;
            a_d     = w_addr_a;
            a_row_d = w_addr_a;
            b_d     = w_addr_b;
            b_col_d = w_addr_b;
            c_d     = w_addr_c;
            d_d     = w_addr_d;
            err_d   = w_zero_dim;
            state_d = w_zero_dim ? S_FINISH : S_ISSUE;
         end
         S_ISSUE: begin
            if (tile_cmd_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (tile_done) state_d = S_ADVANCE;
         end
         S_ADVANCE: begin
            state_d = S_ISSUE;
            if (w_last_k && w_last_n && w_last_m) begin
               state_d = S_FINISH;
            end else if (!w_last_k) begin
               ki_d    = ki_q + 1'b1;
               rem_k_d = rem_k_q - c_W_LW;
               a_d     = a_q + c_W_A;
               b_d     = b_q + ntw_q;
            end else begin
               // New output tile: D/C step by one tile; A returns to the row
               // start, or moves past the row when M advances.
               ki_d    = '0;
               rem_k_d = w_dim_k;
               d_d     = d_q + c_W_A;
               c_d     = c_q + c_W_A;
               if (!w_last_n) begin
                  ni_d    = ni_q + 1'b1;
                  rem_n_d = rem_n_q - c_W_LW;
                  a_d     = a_row_q;
                  b_col_d = b_col_q + c_W_A;
                  b_d     = b_col_q + c_W_A;
               end else begin
                  ni_d    = '0;
                  mi_d    = mi_q + 1'b1;
                  rem_n_d = w_dim_n;
                  rem_m_d = rem_m_q - c_W_LW;
                  a_d     = a_q + c_W_A;
                  a_row_d = a_q + c_W_A;
                  b_d     = w_addr_b;
                  b_col_d = w_addr_b;
               end
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cmd_q   <= '0;
         err_q   <= 1'b0;
         mt_q    <= '0;
         kt_q    <= '0;
         nt_q    <= '0;
         ntw_q   <= '0;
         mi_q    <= '0;
         ni_q    <= '0;
         ki_q    <= '0;
         rem_m_q <= '0;
         rem_n_q <= '0;
         rem_k_q <= '0;
         a_q     <= '0;
         a_row_q <= '0;
         b_q     <= '0;
         b_col_q <= '0;
         c_q     <= '0;
         d_q     <= '0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         err_q   <= err_d;
         mt_q    <= mt_d;
         kt_q    <= kt_d;
         nt_q    <= nt_d;
         ntw_q   <= ntw_d;
         mi_q    <= mi_d;
         ni_q    <= ni_d;
         ki_q    <= ki_d;
         rem_m_q <= rem_m_d;
         rem_n_q <= rem_n_d;
         rem_k_q <= rem_k_d;
         a_q     <= a_d;
         a_row_q <= a_row_d;
         b_q     <= b_d;
         b_col_q <= b_col_d;
         c_q     <= c_d;
         d_q     <= d_d;
      end
   end

   // The first K step reads the C bias; later steps accumulate onto D.
   assign tile_cmd_data  = {d_q, (ki_q == '0) ? c_q : d_q, b_q, a_q,
                            f_len(rem_n_q), f_len(rem_k_q), f_len(rem_m_q)};
   assign tile_cmd_valid = (state_q == S_ISSUE);
   assign cmd_done       = (state_q == S_FINISH);
   assign cmd_err        = (state_q == S_FINISH) && err_q;
   assign busy           = (state_q != S_IDLE) || (level_q != '0);
   assign host_cmd_ready = ready_q;
   assign queue_level    = level_q;

`ifdef GEMM_TILE_PERF_CNT_EN
   logic [31:0] perf_tiles_q, perf_stall_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         perf_tiles_q <= '0;
         perf_stall_q <= '0;
      end else begin
         if ((state_q == S_ISSUE) && tile_cmd_ready && (perf_tiles_q != '1)) begin
            perf_tiles_q <= perf_tiles_q + 1'b1;
         end
         if ((state_q == S_ISSUE) && !tile_cmd_ready && (perf_stall_q != '1)) begin
            perf_stall_q <= perf_stall_q + 1'b1;
         end
      end
   end

   assign perf_tiles = perf_tiles_q;
   assign perf_stall = perf_stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gemm_tile_sequencer.sv
// =============================================================================
// Module   : tb_gemm_tile_sequencer
// Brief    : Directed self-checking bench for gemm_tile_sequencer.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_gemm_tile_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        host_cmd_valid;
   logic        host_cmd_ready;
   logic [75:0] host_cmd_data;
   logic        tile_cmd_valid;
   logic        tile_cmd_ready;
   logic [63:0] tile_cmd_data;
   logic        tile_done;
   logic        busy;
   logic        cmd_done;
   logic        cmd_err;
   logic [2:0]  queue_level;
`ifdef GEMM_TILE_PERF_CNT_EN
   logic [31:0] perf_tiles;
   logic [31:0] perf_stall;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   gemm_tile_sequencer dut (
      .clk            (clk),
      .rst            (rst),
      .host_cmd_valid (host_cmd_valid),
      .host_cmd_ready (host_cmd_ready),
      .host_cmd_data  (host_cmd_data),
      .tile_cmd_valid (tile_cmd_valid),
      .tile_cmd_ready (tile_cmd_ready),
      .tile_cmd_data  (tile_cmd_data),
      .tile_done      (tile_done),
      .busy           (busy),
      .cmd_done       (cmd_done),
      .cmd_err        (cmd_err),
`ifdef GEMM_TILE_PERF_CNT_EN
      .queue_level    (queue_level),
      .perf_tiles     (perf_tiles),
      .perf_stall     (perf_stall)
`else
      .queue_level    (queue_level)
`endif
   );

   function automatic logic [75:0] hcmd(input logic [11:0] m, input logic [11:0] k,
                                        input logic [11:0] n, input logic [9:0] a,
                                        input logic [9:0] b, input logic [9:0] c,
                                        input logic [9:0] d);
      return {d, c, b, a, n, k, m};
   endfunction

   function automatic logic [63:0] tcmd(input logic [9:0] a, input logic [9:0] b,
                                        input logic [9:0] c, input logic [9:0] d,
                                        input logic [7:0] lm, input logic [7:0] lk,
                                        input logic [7:0] ln);
      return {d, c, b, a, ln, lk, lm};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Offer one host command at a negedge; returns at the negedge after acceptance.
   task automatic push(input logic [75:0] d);
      int t;
      t = 0;
      host_cmd_data  = d;
      host_cmd_valid = 1'b1;
      while (!host_cmd_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("push_ready", host_cmd_ready, 1);
      @(posedge clk);
      #1 host_cmd_valid = 1'b0;
      @(negedge clk);
   endtask

   // Wait for a tile offer, check it (and its latency in negedges when lat>=0),
   // complete the handshake and return at the negedge in WAIT.
   task automatic wait_issue(input logic [63:0] exp, input int lat, input string tag);
      int n;
      n = 0;
      while (!tile_cmd_valid && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_valid"}, tile_cmd_valid, 1);
      if (lat >= 0) chk({tag, "_lat"}, n, lat);
      chk({tag, "_data"}, tile_cmd_data, exp);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic done_pulse();
      tile_done = 1'b1;
      @(negedge clk);
      tile_done = 1'b0;
   endtask

   task automatic finish_chk(input logic err, input string tag);
      chk({tag, "_done_early"}, cmd_done, 0);
      @(negedge clk);
      chk({tag, "_done"}, cmd_done, 1);
      chk({tag, "_err"}, cmd_err, err);
   endtask

   logic [63:0] exp3 [4];
   logic [9:0]  a5;

   initial begin
      rst            = 1'b0;
      host_cmd_valid = 1'b0;
      host_cmd_data  = '0;
      tile_cmd_ready = 1'b1;
      tile_done      = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_valid", tile_cmd_valid, 0);
      chk("rst_ready", host_cmd_ready, 1);
      chk("rst_busy",  busy, 0);
      chk("rst_done",  cmd_done, 0);
      chk("rst_err",   cmd_err, 0);
      chk("rst_level", queue_level, 0);
      chk("rst_data",  tile_cmd_data, 0);
`ifdef GEMM_TILE_PERF_CNT_EN
      chk("rst_perf_tiles", perf_tiles, 0);
      chk("rst_perf_stall", perf_stall, 0);
`endif
      rst = 1'b1;
      @(negedge clk);

      // Single tile
      push(hcmd(16, 16, 16, 10'h100, 10'h100, 10'h100, 10'h200));
      chk("t1_busy", busy, 1);
      wait_issue(tcmd(10'h100, 10'h100, 10'h100, 10'h200, 16, 16, 16), 2, "t1");
      done_pulse();
      finish_chk(1'b0, "t1");

      // K split with remainder, C then D chaining
      push(hcmd(16, 40, 16, 10'h000, 10'h040, 10'h100, 10'h200));
      wait_issue(tcmd(10'h000, 10'h040, 10'h100, 10'h200, 16, 16, 16), 2, "t2a");
      done_pulse();
      wait_issue(tcmd(10'h010, 10'h050, 10'h200, 10'h200, 16, 16, 16), 1, "t2b");
      done_pulse();
      wait_issue(tcmd(10'h020, 10'h060, 10'h200, 10'h200, 16, 8, 16), 1, "t2c");
      done_pulse();
      finish_chk(1'b0, "t2");

      // M x N split, mi outer / ni inner
      exp3[0] = tcmd(10'h000, 10'h080, 10'h180, 10'h300, 16, 16, 16);
      exp3[1] = tcmd(10'h000, 10'h090, 10'h190, 10'h310, 16, 16, 4);
      exp3[2] = tcmd(10'h010, 10'h080, 10'h1a0, 10'h320, 16, 16, 16);
      exp3[3] = tcmd(10'h010, 10'h090, 10'h1b0, 10'h330, 16, 16, 4);
      push(hcmd(32, 16, 20, 10'h000, 10'h080, 10'h180, 10'h300));
      for (int i = 0; i < 4; i++) begin
         wait_issue(exp3[i], -1, "t3");
         done_pulse();
      end
      finish_chk(1'b0, "t3");

      // Address wrap modulo 2^10 and a short M edge
      push(hcmd(5, 32, 16, 10'h3f8, 10'h3f0, 10'h000, 10'h3f8));
      wait_issue(tcmd(10'h3f8, 10'h3f0, 10'h000, 10'h3f8, 5, 16, 16), 2, "wr_a");
      done_pulse();
      wait_issue(tcmd(10'h008, 10'h000, 10'h3f8, 10'h3f8, 5, 16, 16), 1, "wr_b");
      done_pulse();
      finish_chk(1'b0, "wr");

      // Zero dimension rejected, following command still runs
      push(hcmd(16, 0, 16, 10'h001, 10'h002, 10'h003, 10'h004));
      push(hcmd(16, 16, 16, 10'h020, 10'h030, 10'h040, 10'h050));
      chk("t4_load_done", cmd_done, 0);
      chk("t4_load_valid", tile_cmd_valid, 0);
      @(negedge clk);
      chk("t4_done", cmd_done, 1);
      chk("t4_err", cmd_err, 1);
      chk("t4_fin_valid", tile_cmd_valid, 0);
      wait_issue(tcmd(10'h020, 10'h030, 10'h040, 10'h050, 16, 16, 16), 3, "t4b");
      done_pulse();
      finish_chk(1'b0, "t4b");

      // Reset while in WAIT with one queued command
      push(hcmd(16, 16, 16, 10'h100, 10'h101, 10'h102, 10'h103));
      push(hcmd(16, 16, 16, 10'h200, 10'h201, 10'h202, 10'h203));
      wait_issue(tcmd(10'h100, 10'h101, 10'h102, 10'h103, 16, 16, 16), -1, "t6");
      chk("t6_level_pre", queue_level, 1);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("t6_valid", tile_cmd_valid, 0);
      chk("t6_ready", host_cmd_ready, 1);
      chk("t6_busy",  busy, 0);
      chk("t6_done",  cmd_done, 0);
      chk("t6_err",   cmd_err, 0);
      chk("t6_level", queue_level, 0);
      chk("t6_data",  tile_cmd_data, 0);
      done_pulse();
      for (int i = 0; i < 4; i++) begin
         chk("t6_stale_done", cmd_done, 0);
         chk("t6_stale_valid", tile_cmd_valid, 0);
         @(negedge clk);
      end
      chk("t6_idle_busy", busy, 0);

      // Back-pressure: 5 accepted, 6th refused, drained in order
      tile_cmd_ready = 1'b0;
      push(hcmd(16, 16, 16, 10'h010, 10'h200, 10'h300, 10'h380));
      @(negedge clk);
      @(negedge clk);
      chk("t5_issue", tile_cmd_valid, 1);
`ifdef GEMM_TILE_PERF_CNT_EN
      chk("t5_stall0", perf_stall, 0);
`endif
      for (int i = 1; i < 5; i++) begin
         a5 = 10'((i + 1) * 16);
         push(hcmd(16, 16, 16, a5, 10'h200, 10'h300, 10'h380));
      end
      chk("t5_level_full", queue_level, 4);
      chk("t5_ready_low", host_cmd_ready, 0);
      host_cmd_data  = hcmd(16, 16, 16, 10'h3c0, 10'h200, 10'h300, 10'h380);
      host_cmd_valid = 1'b1;
      repeat (3) @(negedge clk);
      host_cmd_valid = 1'b0;
      chk("t5_level_held", queue_level, 4);
      chk("t5_ready_held", host_cmd_ready, 0);
`ifdef GEMM_TILE_PERF_CNT_EN
      chk("t5_stall", perf_stall, 7);
      chk("t5_tiles0", perf_tiles, 0);
`endif
      tile_cmd_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         a5 = 10'((i + 1) * 16);
         wait_issue(tcmd(a5, 10'h200, 10'h300, 10'h380, 16, 16, 16), -1, "t5");
         done_pulse();
         finish_chk(1'b0, "t5");
      end
      chk("t5_level_end", queue_level, 0);
      @(negedge clk);
      chk("t5_busy_end", busy, 0);
      chk("t5_no_extra", tile_cmd_valid, 0);
`ifdef GEMM_TILE_PERF_CNT_EN
      chk("t5_tiles", perf_tiles, 5);
      chk("t5_stall_end", perf_stall, 7);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
